// File: rtl/pic_bus_control.sv
// pic_bus_control: CPU-side read/write control for the 8259A.
// Samples the bus strobes, detects the trailing edge of each write pulse,
// decodes ICW1-ICW4 / OCW1-OCW3 and holds the resulting configuration.
module pic_bus_control (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       read_enable_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic       read,
    output logic       read_address,
    output logic       enable_read_register,
    output logic       read_register_isr_or_irr,
    output logic [7:0] interrupt_mask,
    output logic       level_or_edge_triggered,
    output logic       single_or_cascade,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       auto_eoi,
    output logic       special_mask_mode,
    output logic       ocw2_strobe,
    output logic [7:0] ocw2_data,
    output logic       init_done
);

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_wr_active;
    logic       w_rd_active;
    logic       w_commit;

    logic       r_wr_sample;
    logic       r_addr_sample;
    logic [7:0] r_data_sample;

    logic       r_read;
    logic       r_read_address;
    logic       r_enable_read_register;
    logic       r_read_register_isr_or_irr;
    logic [7:0] r_interrupt_mask;
    logic       r_level_or_edge_triggered;
    logic       r_single_or_cascade;
    logic       r_ic4;
    logic [4:0] r_vector_base;
    logic [7:0] r_cascade_config;
    logic       r_auto_eoi;
    logic       r_special_mask_mode;
    logic       r_ocw2_strobe;
    logic [7:0] r_ocw2_data;
    logic       r_init_done;

    logic       w_is_icw1;
    logic       w_is_icw2;
    logic       w_is_icw3;
    logic       w_is_icw4;
    logic       w_is_ocw1;
    logic       w_is_ocw2;
    logic       w_is_ocw3;
    logic       w_finish_init;

    // RD and WR low together means neither cycle is active.
    assign w_wr_active = ~chip_select_n & ~write_enable_n &  read_enable_n;
    assign w_rd_active = ~chip_select_n & ~read_enable_n  &  write_enable_n;

    // A write takes effect once, on the edge where the pulse has just ended.
    assign w_commit    = r_wr_sample & ~w_wr_active;

    // Sample stage: remember whether a write is in progress and its last A0/data.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
        if (reset) begin
            r_wr_sample   <= 1'b0;
            r_addr_sample <= 1'b0;
            r_data_sample <= 8'h00;
        end else begin
            r_wr_sample <= w_wr_active;
            if (w_wr_active) begin
                r_addr_sample <= address;
                r_data_sample <= data_bus_in;
            end
        end
    end

    // Initialization state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Decode the committed write into a command and compute the next init state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state  = r_state;
        w_is_icw1     = 1'b0;
        w_is_icw2     = 1'b0;
        w_is_icw3     = 1'b0;
        w_is_icw4     = 1'b0;
        w_is_ocw1     = 1'b0;
        w_is_ocw2     = 1'b0;
        w_is_ocw3     = 1'b0;
        w_finish_init = 1'b0;
        if (w_commit) begin
            if (!r_addr_sample) begin
                if (r_data_sample[4]) begin
                    // ICW1 always (re)starts the sequence, whatever state we are in.
                    w_is_icw1    = 1'b1;
                    w_next_state = WAIT_ICW2;
                end else if (r_state == READY) begin
                    if (r_data_sample[3]) begin
                        w_is_ocw3 = 1'b1;
                    end else begin
                        w_is_ocw2 = 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    READY: begin
                        w_is_ocw1 = 1'b1;
                    end
                    WAIT_ICW2: begin
                        w_is_icw2 = 1'b1;
                        if (!r_single_or_cascade) begin
                            w_next_state = WAIT_ICW3;
                        end else if (r_ic4) begin
                            w_next_state = WAIT_ICW4;
                        end else begin
                            w_next_state  = READY;
                            w_finish_init = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        w_is_icw3 = 1'b1;
                        if (r_ic4) begin
                            w_next_state = WAIT_ICW4;
                        end else begin
                            w_next_state  = READY;
                            w_finish_init = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        w_is_icw4     = 1'b1;
                        w_next_state  = READY;
                        w_finish_init = 1'b1;
                    end
                    default: begin
                        w_next_state = READY;
                    end
                endcase
            end
        end
    end

    // Read path: registered strobe and A0 for the data bus buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_read         <= 1'b0;
            r_read_address <= 1'b0;
        end else begin
            r_read         <= w_rd_active;
            r_read_address <= address;
        end
    end

    // Configuration registers written by the decoded ICW/OCW commands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enable_read_register     <= 1'b1;
            r_read_register_isr_or_irr <= 1'b0;
            r_interrupt_mask           <= 8'h00;
            r_level_or_edge_triggered  <= 1'b0;
            r_single_or_cascade        <= 1'b0;
            r_ic4                      <= 1'b0;
            r_vector_base              <= 5'h00;
            r_cascade_config           <= 8'h00;
            r_auto_eoi                 <= 1'b0;
            r_special_mask_mode        <= 1'b0;
            r_ocw2_strobe              <= 1'b0;
            r_ocw2_data                <= 8'h00;
            r_init_done                <= 1'b0;
        end else begin
            r_ocw2_strobe <= w_is_ocw2;

            if (w_is_icw1) begin
                r_level_or_edge_triggered  <= r_data_sample[3];
                r_single_or_cascade        <= r_data_sample[1];
                r_ic4                      <= r_data_sample[0];
                r_interrupt_mask           <= 8'h00;
                r_auto_eoi                 <= 1'b0;
                r_special_mask_mode        <= 1'b0;
                r_enable_read_register     <= 1'b1;
                r_read_register_isr_or_irr <= 1'b0;
                r_init_done                <= 1'b0;
            end else if (w_finish_init) begin
                r_init_done <= 1'b1;
            end

            if (w_is_icw2) begin
                r_vector_base <= r_data_sample[7:3];
            end
            if (w_is_icw3) begin
                r_cascade_config <= r_data_sample;
            end
            if (w_is_icw4) begin
                r_auto_eoi <= r_data_sample[1];
            end
            if (w_is_ocw1) begin
                r_interrupt_mask <= r_data_sample;
            end
            if (w_is_ocw2) begin
                r_ocw2_data <= r_data_sample;
            end
            if (w_is_ocw3) begin
                // RR selects the readable register; ESMM gates the SMM bit.
                if (r_data_sample[1]) begin
                    r_enable_read_register     <= 1'b1;
                    r_read_register_isr_or_irr <= r_data_sample[0];
                end
                if (r_data_sample[6]) begin
                    r_special_mask_mode <= r_data_sample[5];
                end
            end
        end
    end

    assign read                     = r_read;
    assign read_address             = r_read_address;
    assign enable_read_register     = r_enable_read_register;
    assign read_register_isr_or_irr = r_read_register_isr_or_irr;
    assign interrupt_mask           = r_interrupt_mask;
    assign level_or_edge_triggered  = r_level_or_edge_triggered;
    assign single_or_cascade        = r_single_or_cascade;
    assign vector_base              = r_vector_base;
    assign cascade_config           = r_cascade_config;
    assign auto_eoi                 = r_auto_eoi;
    assign special_mask_mode        = r_special_mask_mode;
    assign ocw2_strobe              = r_ocw2_strobe;
    assign ocw2_data                = r_ocw2_data;
    assign init_done                = r_init_done;

endmodule
